// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with one registered output stage.
// The channel comes either from the manual sel input (MODE=0) or from round-robin arbitration (MODE=1).
module stream_mux_arb #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = 1,
  parameter int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_ch
);

  logic [SEL_W-1:0] rr_ptr;
  logic [N_CH-1:0]  grant;
  logic             found;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;

  assign load_en = !out_valid || out_ready;

  // One-hot grant. Round-robin searches channels above rr_ptr first, then wraps to the rest.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (MODE == 0) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (SEL_W'(i) == sel && in_valid[i]) begin
          grant[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (!found && in_valid[i] && (SEL_W'(i) > rr_ptr)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
      for (int i = 0; i < int'(N_CH); i++) begin
        if (!found && in_valid[i] && (SEL_W'(i) <= rr_ptr)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  // Index and payload of the granted channel.
  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (grant[i]) begin
        grant_idx  = SEL_W'(i);
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // rst_n gating keeps every in_ready low while the block is held in reset.
  assign in_ready = {N_CH{rst_n && load_en}} & grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(N_CH - 1);
    end else if (load_en) begin
      if (|grant) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
        if (MODE != 0) begin
          rr_ptr <= grant_idx;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: round-robin (N=4), manual (N=4) and manual (N=3) instances share one stimulus.
// A queue-free distance-search reference model predicts in_ready and the output register of each instance.
module tb_stream_mux_arb;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0] rdy0, rdy1;
  logic [2:0] rdy2;
  logic [7:0] od0, od1, od2;
  logic       ov0, ov1, ov2;
  logic [1:0] oc0, oc1, oc2;

  int vectors;
  int miscompares;

  // Reference state per instance: held beat and last granted channel.
  logic       mv[3];
  logic [7:0] md[3];
  int         mc[3];
  int         last[3];

  stream_mux_arb #(.N_CH(4), .WIDTH(8), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .sel(sel), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_ch(oc0));

  stream_mux_arb #(.N_CH(4), .WIDTH(8), .MODE(0)) dut_man (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .sel(sel), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_ch(oc1));

  stream_mux_arb #(.N_CH(3), .WIDTH(8), .MODE(0)) dut_man3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(rdy2),
    .sel(sel), .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .out_ch(oc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input int d);
    return (d == 2) ? 3 : 4;
  endfunction

  // Channel that should win this cycle, or -1.
  function automatic int pick(input int d);
    int n;
    int c;
    n = n_of(d);
    if (d == 0) begin
      for (int k = 1; k <= n; k++) begin
        c = (last[d] + k) % n;
        if (in_valid[c]) return c;
      end
      return -1;
    end
    if (int'(sel) < n && in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mv[d] = 1'b0;
      md[d] = 8'h00;
      mc[d] = 0;
      last[d] = n_of(d) - 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_v0"}, 32'(ov0), 32'(mv[0]));
    chk({tag, "_d0"}, 32'(od0), 32'(md[0]));
    chk({tag, "_c0"}, 32'(oc0), 32'(mc[0]));
    chk({tag, "_v1"}, 32'(ov1), 32'(mv[1]));
    chk({tag, "_d1"}, 32'(od1), 32'(md[1]));
    chk({tag, "_c1"}, 32'(oc1), 32'(mc[1]));
    chk({tag, "_v2"}, 32'(ov2), 32'(mv[2]));
    chk({tag, "_d2"}, 32'(od2), 32'(md[2]));
    chk({tag, "_c2"}, 32'(oc2), 32'(mc[2]));
  endtask

  // Starts at a falling edge with inputs already driven; ends at the next falling edge.
  task automatic cycle(input string tag);
    int         g[3];
    logic [3:0] er[3];
    logic       le;
    #1;
    for (int d = 0; d < 3; d++) begin
      g[d] = pick(d);
      le = !mv[d] || out_ready;
      er[d] = (rst_n && le && g[d] >= 0) ? 4'(1 << g[d]) : 4'd0;
    end
    chk({tag, "_rdy0"}, 32'(rdy0), 32'(er[0]));
    chk({tag, "_rdy1"}, 32'(rdy1), 32'(er[1]));
    chk({tag, "_rdy2"}, 32'(rdy2), 32'(er[2]));
    @(posedge clk);
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (!mv[d] || out_ready) begin
          if (g[d] >= 0) begin
            mv[d] = 1'b1;
            md[d] = in_data[g[d]*8 +: 8];
            mc[d] = g[d];
            if (d == 0) last[d] = g[d];
          end else begin
            mv[d] = 1'b0;
          end
        end
      end
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  logic [7:0] held;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in_data = 32'hA3A2A1A0;
    in_valid = 4'h0;
    sel = 2'd0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    check_outputs("reset");
    chk("reset_rdy0", 32'(rdy0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with every channel valid.
    in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom;
      cycle("rr");
      chk("rr_order", 32'(oc0), 32'(i % 4));
    end

    // Asynchronous reset while a beat is held.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst_rdy0", 32'(rdy0), 32'h0);
    @(negedge clk);
    cycle("in_rst");
    rst_n = 1'b1;
    in_data = 32'hA3A2A1A0;
    in_valid = 4'hF;
    cycle("post_rst");
    chk("post_rst_data", 32'(od0), 32'hA0);
    chk("post_rst_ch", 32'(oc0), 32'h0);

    // Sparse requests on channels 1 and 3, then drain.
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      cycle("sparse");
    end
    chk("sparse_ch", 32'(oc0), 32'd1);
    in_valid = 4'h0;
    cycle("drain");
    chk("drain_valid", 32'(ov0), 32'h0);

    // Back-pressure: held beat and arbitration pointer stay frozen.
    in_valid = 4'hF;
    in_data = 32'h5A5A5A5A;
    cycle("bp_load");
    held = od0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      cycle("bp");
      chk("bp_hold", 32'(od0), 32'(held));
    end
    out_ready = 1'b1;
    cycle("bp_rel");
    cycle("bp_next");

    // Manual select: channel 2 only, then switch to channel 0.
    sel = 2'd2;
    in_valid = 4'b0101;
    in_data = 32'h00110000;
    cycle("man_a");
    in_data = 32'h00220000;
    cycle("man_b");
    chk("man_ch2", 32'(oc1), 32'd2);
    chk("man_d22", 32'(od1), 32'h22);
    sel = 2'd0;
    in_data = 32'h00330044;
    cycle("man_sw");
    chk("man_ch0", 32'(oc1), 32'd0);

    // Out-of-range select on the three-channel instance.
    sel = 2'd3;
    in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      cycle("oor");
      chk("oor_valid", 32'(ov2), 32'h0);
    end

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      in_data = $urandom;
      in_valid = 4'($urandom);
      sel = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised N-channel, W-bit successor to the team's 2:1 selectors.
- Multiplexes N valid/ready input streams onto one registered output stream.
- Channel choice is either a manual `sel` input (MODE=0) or internal round-robin arbitration (MODE=1).
- Sits between several producer blocks and a single shared consumer; one output register stage gives full throughput and 1-cycle latency.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel in bits.
- MODE, 1, 0 = manual select via `sel`; 1 = round-robin arbitration.
- SEL_W, $clog2(N_CH) (minimum 1), width of channel index signals (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; combinational.
- sel  input  SEL_W  manual channel select; used only when MODE=0.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, sync release) clears: out_valid=0, out_data=0, out_ch=0, rr_ptr=N_CH-1, so channel 0 has first priority after reset.
- Reset mid-transfer drops the held beat. No in_ready is asserted while rst_n=0.
- load_en = !out_valid || out_ready. The output register accepts a new beat in any cycle with load_en=1.
- Grant is computed combinationally each cycle and is one-hot or zero:
  - MODE=0: grant[sel] = in_valid[sel]. If sel >= N_CH (non-power-of-2 N_CH), no grant.
  - MODE=1: grant goes to the first channel with in_valid=1, searching upward from (rr_ptr+1) mod N_CH and wrapping.
- in_ready[i] = load_en && grant[i]. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On transfer: out_data <= channel data, out_ch <= i, out_valid <= 1. In MODE=1 only, rr_ptr <= i.
- If load_en=1 and there is no grant: out_valid <= 0. out_data and out_ch hold their last values.
- If load_en=0: all registers hold, all in_ready=0, and rr_ptr does not advance.
- Latency: an input beat appears on the output the cycle after its transfer.
- Throughput: 1 beat per cycle while out_ready=1.
- Simultaneous pop and push (out_valid && out_ready && new grant) reloads the register in the same edge, with no bubble.
- Stream rules:
  - out_valid && !out_ready ⇒ out_data and out_ch are stable until accepted.
  - in_valid may depend on nothing from this block. in_ready never depends on in_data.
- Fairness (MODE=1): with all channels continuously valid, grants cycle 0,1,..,N_CH-1,0,...
  - Each channel waits at most N_CH-1 transfers.
  - Stalls (out_ready=0) do not change the order.
- Changing `sel` mid-stream (MODE=0) takes effect on the next load cycle. A beat already registered is unaffected.
- No data is lost or duplicated: every transfer produces exactly one output acceptance.

Test Plan:
1. Reset check: assert rst_n=0 mid-stream with out_valid=1 → out_valid, out_data, out_ch drop to 0 immediately (async). After release, with all 4 channels valid (data 0xA0..0xA3), the first output is 0xA0 with out_ch=0.
2. Round-robin order: MODE=1, N_CH=4, WIDTH=8, all in_valid=1, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3, one beat per cycle, no bubbles.
3. Sparse requests: only ch1 and ch3 valid → outputs alternate ch1, ch3, ch1. in_ready[0] and in_ready[2] stay 0. Then drop all valids → out_valid=0 after the last beat is accepted.
4. Back-pressure: out_ready=0 for 5 cycles with out_valid=1, data 0x5A → out_data holds 0x5A, all in_ready=0, and rr_ptr is frozen. On release, the next grant is the channel after the stalled one.
5. Manual mode: MODE=0, sel=2, ch2 sends 0x11,0x22 and ch0 is valid → only ch2 beats appear (out_ch=2). Switch sel=0 → the next beat comes from ch0.
6. Out-of-range select: MODE=0, N_CH=3, sel=3 with all channels valid → no in_ready asserted and out_valid stays 0.
